// File: rtl/alu_rr_sched_pkg.sv
// Shared types and constants for the round-robin ALU scheduler.
// Contents: ALU opcode enum, scheduler FSM state enum, ALU width and
// scheduler latency constants, saturating counter helper.
package alu_rr_sched_pkg;

    localparam int unsigned ALU_DW    = 4;
    localparam int unsigned SCHED_LAT = 3;
    localparam int unsigned STAT_W    = 16;

    typedef enum logic [1:0] {
        ADD            = 2'd0,
        SUB            = 2'd1,
        NOT_A          = 2'd2,
        REDUCTION_OR_B = 2'd3
    } opcode_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        CAPT = 2'd2,
        RESP = 2'd3
    } sched_state_e;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
        return (v == {STAT_W{1'b1}}) ? v : v + STAT_W'(1);
    endfunction

endpackage

// File: rtl/alu_rr_sched_rr_arbiter.sv
// Combinational round-robin arbiter.
// Searches i_valid starting at i_ptr+1 (mod N_REQ) and returns the first
// set requester as a one-hot grant plus its index.
// Ports:
//   i_valid   [N_REQ]  request vector
//   i_ptr     [IW]     index of the last winner
//   o_grant_c [N_REQ]  one-hot grant (zero when no request)
//   o_idx_c   [IW]     index of the granted requester
//   o_any_c            at least one request is pending
module rr_arbiter #(
    parameter  int unsigned N_REQ = 4,
    localparam int unsigned IW    = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] i_valid,
    input  logic [IW-1:0]    i_ptr,
    output logic [N_REQ-1:0] o_grant_c,
    output logic [IW-1:0]    o_idx_c,
    output logic             o_any_c
);

    int unsigned w_k;
    logic [IW-1:0] w_kidx;
    logic w_found;

    // First valid requester after the pointer wins; the pointer itself is
    // searched last, which lets a lone requester win repeatedly.
    always_comb begin
        o_grant_c = '0;
        o_idx_c   = '0;
        w_found   = 1'b0;
        w_k       = 0;
        w_kidx    = '0;
        for (int unsigned i = 1; i <= N_REQ; i++) begin
            w_k    = (32'(i_ptr) + i) % N_REQ;
            w_kidx = IW'(w_k);
            if (!w_found && i_valid[w_kidx]) begin
                w_found           = 1'b1;
                o_idx_c           = w_kidx;
                o_grant_c[w_kidx] = 1'b1;
            end
        end
        o_any_c = w_found;
    end

endmodule

// File: rtl/alu_rr_sched.sv
// Round-robin scheduler sharing one registered ALU between N_REQ requesters.
// One operation in flight at a time: accept (IDLE) -> ALU computes (EXEC)
// -> result captured (CAPT) -> response held until accepted (RESP).
// Ports:
//   clk, reset                    clock, synchronous active-high reset
//   req_valid/req_ready [N_REQ]   per-requester request handshake
//                                 (req_ready is combinational, one-hot)
//   req_opcode/req_a/req_b        flattened per-requester payloads
//   rsp_valid/rsp_ready           response handshake
//   rsp_id, rsp_data              owner index and ALU result
//   alu_opcode/alu_a/alu_b        registered operands to the ALU
//   alu_c                         registered ALU result
//   stat_grant_cnt                per-requester 16-bit saturating grant
//                                 counters, present only when
//                                 ALU_RR_SCHED_STATS_EN is defined
module alu_rr_sched
    import alu_rr_sched_pkg::*;
#(
    parameter  int unsigned N_REQ = 4,
    parameter  int unsigned DW    = ALU_DW,
    localparam int unsigned IW    = $clog2(N_REQ)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N_REQ-1:0]     req_valid,
    output logic [N_REQ-1:0]     req_ready,
    input  logic [N_REQ*2-1:0]   req_opcode,
    input  logic [N_REQ*DW-1:0]  req_a,
    input  logic [N_REQ*DW-1:0]  req_b,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [IW-1:0]        rsp_id,
    output logic [DW:0]          rsp_data,
    output logic [1:0]           alu_opcode,
    output logic [DW-1:0]        alu_a,
    output logic [DW-1:0]        alu_b,
    input  logic [DW:0]          alu_c
`ifdef ALU_RR_SCHED_STATS_EN
    ,
    output logic [N_REQ*STAT_W-1:0] stat_grant_cnt
`endif
);

    sched_state_e r_state, w_state_nxt;

    logic [IW-1:0]    r_ptr;
    logic [IW-1:0]    r_id;
    opcode_e          r_alu_op;
    logic [DW-1:0]    r_alu_a;
    logic [DW-1:0]    r_alu_b;
    logic             r_rsp_valid;
    logic [IW-1:0]    r_rsp_id;
    logic [DW:0]      r_rsp_data;

    logic [N_REQ-1:0] w_win_grant;
    logic [IW-1:0]    w_win_idx;
    logic             w_any;
    logic             w_accept;

    logic [1:0]       w_op [N_REQ];
    logic [DW-1:0]    w_a  [N_REQ];
    logic [DW-1:0]    w_b  [N_REQ];

    // Split flattened request payloads into per-requester arrays.
    for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
        assign w_op[g] = req_opcode[g*2 +: 2];
        assign w_a[g]  = req_a[g*DW +: DW];
        assign w_b[g]  = req_b[g*DW +: DW];
    end

    rr_arbiter #(
        .N_REQ (N_REQ)
    ) u_arb (
        .i_valid   (req_valid),
        .i_ptr     (r_ptr),
        .o_grant_c (w_win_grant),
        .o_idx_c   (w_win_idx),
        .o_any_c   (w_any)
    );

    assign w_accept = (r_state == IDLE) && w_any;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    // Next state and the combinational grant.
    always_comb begin
        w_state_nxt = r_state;
        req_ready   = '0;
        case (r_state)
            IDLE: begin
                if (w_any) begin
                    req_ready   = w_win_grant;
                    w_state_nxt = EXEC;
                end
            end
            EXEC:    w_state_nxt = CAPT;
            CAPT:    w_state_nxt = RESP;
            RESP:    if (rsp_ready) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Operand, pointer and response registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ptr       <= IW'(N_REQ - 1);
            r_id        <= '0;
            r_alu_op    <= ADD;
            r_alu_a     <= '0;
            r_alu_b     <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= '0;
            r_rsp_data  <= '0;
        end else begin
            if (w_accept) begin
                r_alu_op <= opcode_e'(w_op[w_win_idx]);
                r_alu_a  <= w_a[w_win_idx];
                r_alu_b  <= w_b[w_win_idx];
                r_id     <= w_win_idx;
                r_ptr    <= w_win_idx;
            end
            // ALU output registered during EXEC is valid in CAPT.
            if (r_state == CAPT) begin
                r_rsp_valid <= 1'b1;
                r_rsp_id    <= r_id;
                r_rsp_data  <= alu_c;
            end else if ((r_state == RESP) && rsp_ready) begin
                r_rsp_valid <= 1'b0;
            end
        end
    end

    assign alu_opcode = r_alu_op;
    assign alu_a      = r_alu_a;
    assign alu_b      = r_alu_b;
    assign rsp_valid  = r_rsp_valid;
    assign rsp_id     = r_rsp_id;
    assign rsp_data   = r_rsp_data;

`ifdef ALU_RR_SCHED_STATS_EN
    logic [STAT_W-1:0] r_stat [N_REQ];

    // Per-requester grant counters, bumped on each accept edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < N_REQ; i++) r_stat[i] <= '0;
        end else if (w_accept) begin
            r_stat[w_win_idx] <= sat_inc(r_stat[w_win_idx]);
        end
    end

    for (genvar g = 0; g < N_REQ; g++) begin : g_stat
        assign stat_grant_cnt[g*STAT_W +: STAT_W] = r_stat[g];
    end
`endif

endmodule
